// File: rtl/mul_issue_unit.sv
// rtl/mul_issue_unit.sv - M-extension multiply issue unit
// Sequences one op at a time through an external shift-add multiplier and hands the result to the CDB.
module mul_issue_unit #(
  parameter int OPERAND_WIDTH = 32,
  parameter int TAG_WIDTH     = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       branch_mispredicted,
  input  logic                       issue_valid,
  output logic                       issue_ready,
  input  logic [2:0]                 issue_funct3,
  input  logic [OPERAND_WIDTH-1:0]   issue_rs1,
  input  logic [OPERAND_WIDTH-1:0]   issue_rs2,
  input  logic [TAG_WIDTH-1:0]       issue_tag,
  input  logic [4:0]                 issue_rd,
  output logic                       mul_start,
  output logic [1:0]                 mul_type,
  output logic [OPERAND_WIDTH-1:0]   mul_a,
  output logic [OPERAND_WIDTH-1:0]   mul_b,
  input  logic [2*OPERAND_WIDTH-1:0] mul_p,
  input  logic                       mul_done,
  output logic                       cdb_valid,
  input  logic                       cdb_ready,
  output logic [TAG_WIDTH-1:0]       cdb_tag,
  output logic [4:0]                 cdb_rd,
  output logic [OPERAND_WIDTH-1:0]   cdb_data
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BUSY   = 2'd1,
    S_RESULT = 2'd2
  } state_t;

  state_t                     r_state;
  state_t                     w_next;
  logic [1:0]                 r_funct;
  logic [1:0]                 r_mul_type;
  logic                       r_mul_start;
  logic [OPERAND_WIDTH-1:0]   r_mul_a;
  logic [OPERAND_WIDTH-1:0]   r_mul_b;
  logic [TAG_WIDTH-1:0]       r_cdb_tag;
  logic [4:0]                 r_cdb_rd;
  logic [OPERAND_WIDTH-1:0]   r_cdb_data;
  logic                       w_accept;
  logic                       w_trivial;
  logic                       w_capture;
  logic [1:0]                 w_type;

  assign issue_ready = (r_state == S_IDLE) && !branch_mispredicted && !rst;
  assign w_accept    = issue_valid && issue_ready;
  // Non-multiply funct3 codes and zero operands resolve to 0 without touching the multiplier.
  assign w_trivial   = issue_funct3[2] || (issue_rs1 == '0) || (issue_rs2 == '0);
  assign w_capture   = (r_state == S_BUSY) && mul_done && !branch_mispredicted;

  always_comb begin
    w_type = 2'b00;
    case (issue_funct3[1:0])
      2'b01:   w_type = 2'b01;
      2'b10:   w_type = 2'b10;
      default: w_type = 2'b00;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = w_trivial ? S_RESULT : S_BUSY;
        end
      end
      S_BUSY: begin
        if (mul_done) begin
          w_next = S_RESULT;
        end
      end
      S_RESULT: begin
        if (cdb_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
    if (branch_mispredicted) begin
      w_next = S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_funct     <= 2'b00;
      r_mul_type  <= 2'b00;
      r_mul_start <= 1'b0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_cdb_tag   <= '0;
      r_cdb_rd    <= 5'd0;
      r_cdb_data  <= '0;
    end else begin
      // Registered copy of the next state keeps mul_start glitch-free and high exactly in BUSY.
      r_mul_start <= (w_next == S_BUSY);
      if (w_accept) begin
        r_funct    <= issue_funct3[1:0];
        r_mul_type <= w_type;
        r_mul_a    <= issue_rs1;
        r_mul_b    <= issue_rs2;
        r_cdb_tag  <= issue_tag;
        r_cdb_rd   <= issue_rd;
        if (w_trivial) begin
          r_cdb_data <= '0;
        end
      end
      if (w_capture) begin
        r_cdb_data <= (r_funct == 2'b00) ? mul_p[OPERAND_WIDTH-1:0]
                                         : mul_p[2*OPERAND_WIDTH-1:OPERAND_WIDTH];
      end
    end
  end

  assign mul_start = r_mul_start;
  assign mul_type  = r_mul_type;
  assign mul_a     = r_mul_a;
  assign mul_b     = r_mul_b;
  assign cdb_valid = (r_state == S_RESULT);
  assign cdb_tag   = r_cdb_tag;
  assign cdb_rd    = r_cdb_rd;
  assign cdb_data  = r_cdb_data;

endmodule

// File: tb/tb_mul_issue_unit.sv
// tb/tb_mul_issue_unit.sv - self-checking bench for mul_issue_unit
// Includes a behavioural 65-cycle multiplier and a transaction-level reference model.
module tb_mul_issue_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        branch_mispredicted;
  logic        issue_valid;
  logic        issue_ready;
  logic [2:0]  issue_funct3;
  logic [31:0] issue_rs1;
  logic [31:0] issue_rs2;
  logic [4:0]  issue_tag;
  logic [4:0]  issue_rd;
  logic        mul_start;
  logic [1:0]  mul_type;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [63:0] mul_p;
  logic        mul_done;
  logic        cdb_valid;
  logic        cdb_ready;
  logic [4:0]  cdb_tag;
  logic [4:0]  cdb_rd;
  logic [31:0] cdb_data;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  mul_issue_unit #(.OPERAND_WIDTH(32), .TAG_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .branch_mispredicted(branch_mispredicted),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_funct3(issue_funct3),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_tag(issue_tag), .issue_rd(issue_rd),
    .mul_start(mul_start), .mul_type(mul_type), .mul_a(mul_a), .mul_b(mul_b),
    .mul_p(mul_p), .mul_done(mul_done), .cdb_valid(cdb_valid), .cdb_ready(cdb_ready),
    .cdb_tag(cdb_tag), .cdb_rd(cdb_rd), .cdb_data(cdb_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier stand-in: done after 65 edges of continuous start.
  int   mcnt = 0;
  logic spur = 1'b0;
  always @(posedge clk) mcnt <= mul_start ? mcnt + 1 : 0;
  assign mul_done = (mcnt == 65) || spur;
  always_comb begin
    logic signed [127:0] xa, xb, xp;
    xa = (mul_type != 2'b00) ? {{96{mul_a[31]}}, mul_a} : {96'd0, mul_a};
    xb = (mul_type == 2'b01) ? {{96{mul_b[31]}}, mul_b} : {96'd0, mul_b};
    xp = xa * xb;
    mul_p = xp[63:0];
  end

  function automatic logic [31:0] ref_result(logic [2:0] f, logic [31:0] a, logic [31:0] b);
    logic signed [127:0] sa, sb, p;
    sa = (f == 3'd3) ? {96'd0, a} : {{96{a[31]}}, a};
    sb = (f == 3'd1) ? {{96{b[31]}}, b} : {96'd0, b};
    p  = sa * sb;
    if (f[2] || a == 0 || b == 0) return 32'd0;
    if (f == 3'd0) return p[31:0];
    return p[63:32];
  endfunction

  // Reference model: phase 0 waiting for an op, 1 multiplying, 2 offering the result.
  int          m_phase = 0;
  logic [2:0]  m_f3;
  logic [31:0] m_a, m_b, m_data;
  logic [4:0]  m_tag, m_rd;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0;
    end else if (branch_mispredicted) begin
      m_phase = 0;
    end else if (m_phase == 0) begin
      if (issue_valid) begin
        m_f3 = issue_funct3; m_a = issue_rs1; m_b = issue_rs2;
        m_tag = issue_tag; m_rd = issue_rd;
        m_data = ref_result(issue_funct3, issue_rs1, issue_rs2);
        m_phase = (issue_funct3[2] || issue_rs1 == 0 || issue_rs2 == 0) ? 2 : 1;
      end
    end else if (m_phase == 1) begin
      if (mul_done) m_phase = 2;
    end else if (cdb_ready) begin
      m_phase = 0;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    chk("issue_ready", 64'(issue_ready), 64'(m_phase == 0 && !branch_mispredicted && !rst));
    chk("mul_start", 64'(mul_start), 64'(m_phase == 1));
    chk("cdb_valid", 64'(cdb_valid), 64'(m_phase == 2));
    if (m_phase == 1) begin
      chk("mul_a", 64'(mul_a), 64'(m_a));
      chk("mul_b", 64'(mul_b), 64'(m_b));
      chk("mul_type", 64'(mul_type), (m_f3 == 3'd1) ? 64'd1 : (m_f3 == 3'd2) ? 64'd2 : 64'd0);
    end
    if (m_phase == 2) begin
      chk("cdb_data", 64'(cdb_data), 64'(m_data));
      chk("cdb_tag", 64'(cdb_tag), 64'(m_tag));
      chk("cdb_rd", 64'(cdb_rd), 64'(m_rd));
    end
  end

  int t_acc;

  task automatic do_issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag, input logic [4:0] rd);
    issue_valid = 1'b1; issue_funct3 = f; issue_rs1 = a; issue_rs2 = b;
    issue_tag = tag; issue_rd = rd;
    @(posedge clk); #1 t_acc = cyc;
    #1 issue_valid = 1'b0;
  endtask

  task automatic wait_cdb(input string name, input int limit, input int exp_lat,
                          input logic [31:0] exp_data, input logic [4:0] tag, input logic [4:0] rd);
    bit found = 0;
    for (int i = 0; i < limit && !found; i++) begin
      @(negedge clk);
      if (cdb_valid) found = 1;
    end
    if (!found) begin
      n_vec++; n_bad++;
      $display("FAIL %s: cdb_valid timeout after %0d cycles", name, limit);
    end else begin
      if (exp_lat >= 0) chk({name, "_latency"}, 64'(cyc - t_acc), 64'(exp_lat));
      chk({name, "_data"}, 64'(cdb_data), 64'(exp_data));
      chk({name, "_tag"}, 64'(cdb_tag), 64'(tag));
      chk({name, "_rd"}, 64'(cdb_rd), 64'(rd));
    end
    @(posedge clk); #2;
  endtask

  initial begin
    rst = 1'b1; branch_mispredicted = 1'b0; issue_valid = 1'b0; issue_funct3 = 3'd0;
    issue_rs1 = 32'd0; issue_rs2 = 32'd0; issue_tag = 5'd0; issue_rd = 5'd0; cdb_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_issue_ready", 64'(issue_ready), 64'd0);
    chk("rst_outputs", {mul_start, cdb_valid, mul_type, cdb_tag, cdb_rd}, 64'd0);
    chk("rst_mul_ab", {mul_a, mul_b}, 64'd0);
    chk("rst_cdb_data", 64'(cdb_data), 64'd0);
    @(posedge clk); #2 rst = 1'b0;

    cdb_ready = 1'b1;
    do_issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 5'd9);
    wait_cdb("mul_7x-3", 200, 66, 32'hFFFF_FFEB, 5'd5, 5'd9);
    do_issue(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, 5'd2);
    wait_cdb("mulh", 200, 66, 32'h4000_0000, 5'd1, 5'd2);
    do_issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 5'd3);
    wait_cdb("mulhsu", 200, 66, 32'hFFFF_FFFF, 5'd2, 5'd3);
    do_issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 5'd4);
    wait_cdb("mulhu", 200, 66, 32'hFFFF_FFFE, 5'd3, 5'd4);
    do_issue(3'd3, 32'd0, 32'd5, 5'd4, 5'd5);
    wait_cdb("mulhu_zero", 3, 0, 32'd0, 5'd4, 5'd5);
    do_issue(3'd4, 32'd9, 32'd9, 5'd6, 5'd7);
    wait_cdb("funct3_div", 3, 0, 32'd0, 5'd6, 5'd7);

    cdb_ready = 1'b0;
    do_issue(3'd0, 32'd3, 32'd4, 5'd7, 5'd3);
    wait_cdb("hold", 200, 66, 32'd12, 5'd7, 5'd3);
    issue_valid = 1'b1; issue_funct3 = 3'd1; issue_rs1 = 32'd8; issue_rs2 = 32'd8;
    repeat (10) begin @(posedge clk); #2; end
    @(negedge clk);
    chk("hold_data", 64'(cdb_data), 64'd12);
    chk("hold_valid", 64'(cdb_valid), 64'd1);
    @(posedge clk); #2 cdb_ready = 1'b1; issue_valid = 1'b0;
    @(posedge clk); #2;
    @(negedge clk);
    chk("handoff_idle", {cdb_valid, issue_ready}, 64'd1);
    @(posedge clk); #2;

    do_issue(3'd0, 32'h1234, 32'h5678, 5'd8, 5'd8);
    repeat (19) begin @(posedge clk); #2; end
    branch_mispredicted = 1'b1; issue_valid = 1'b1; issue_funct3 = 3'd3;
    issue_rs1 = 32'd1; issue_rs2 = 32'd1;
    @(posedge clk); #2 branch_mispredicted = 1'b0; issue_valid = 1'b0;
    @(negedge clk);
    chk("flush_state", {mul_start, cdb_valid, issue_ready}, 64'd1);
    repeat (80) begin @(posedge clk); #2; end
    do_issue(3'd3, 32'hDEAD_BEEF, 32'h10, 5'd9, 5'd10);
    wait_cdb("after_flush", 200, 66, 32'hD, 5'd9, 5'd10);

    spur = 1'b1; @(posedge clk); #2 spur = 1'b0;
    @(negedge clk);
    chk("spurious_done_idle", {mul_start, cdb_valid}, 64'd0);
    @(posedge clk); #2;

    cdb_ready = 1'b0;
    do_issue(3'd0, 32'd5, 32'd5, 5'd11, 5'd12);
    wait_cdb("spur_result", 200, 66, 32'd25, 5'd11, 5'd12);
    spur = 1'b1; @(posedge clk); #2 spur = 1'b0;
    @(negedge clk);
    chk("spur_result_data", 64'(cdb_data), 64'd25);
    #1 rst = 1'b1;
    #1 chk("async_rst_valid", {cdb_valid, issue_ready}, 64'd0);
    chk("async_rst_data", 64'(cdb_data), 64'd0);
    @(posedge clk); #2 rst = 1'b0; cdb_ready = 1'b1;
    repeat (5) begin @(posedge clk); #2; end

    do_issue(3'd0, 32'd6, 32'd7, 5'd13, 5'd14);
    repeat (10) begin @(posedge clk); #2; end
    @(negedge clk); #1 rst = 1'b1;
    #1 chk("async_rst_busy", 64'(mul_start), 64'd0);
    @(posedge clk); #2 rst = 1'b0;
    repeat (70) begin @(posedge clk); #2; end
    do_issue(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd15, 5'd16);
    wait_cdb("final_mul", 200, 66, 32'd1, 5'd15, 5'd16);
    repeat (3) begin @(posedge clk); #2; end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
